// File: rtl/vram_arbiter_if.sv
// Bundle of the three VRAM client ports and the BRAM port seen by vram_arbiter.
// The slave modport is the arbiter's view; master is the clients/memory side.
interface vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          DREQ;
  logic [AW-1:0] DADDR;
  logic [DW-1:0] DDATA;
  logic          DVALID;
  logic          WREQ;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] WDATA;
  logic          WACK;
  logic          CLR;
  logic          BUSY;
  logic          DONE;
  logic          MEN;
  logic          MWE;
  logic [AW-1:0] MADDR;
  logic [DW-1:0] MWDATA;
  logic [DW-1:0] MRDATA;

  modport slave (
    input  DREQ, DADDR, WREQ, WADDR, WDATA, CLR, MRDATA,
    output DDATA, DVALID, WACK, BUSY, DONE, MEN, MWE, MADDR, MWDATA
  );

  modport master (
    output DREQ, DADDR, WREQ, WADDR, WDATA, CLR, MRDATA,
    input  DDATA, DVALID, WACK, BUSY, DONE, MEN, MWE, MADDR, MWDATA
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads beat the clear/fill sequencer,
// which beats the general write client. One grant per cycle.
module vram_arbiter #(
  parameter int            AW    = 16,
  parameter int            DW    = 8,
  parameter int            DEPTH = 38400,
  parameter logic [DW-1:0] FILL  = '0
) (
  input logic           CLK,
  input logic           RST,
  vram_arbiter_if.slave bus
);

  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_FILL = 1'b1;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic          done_q;
  logic          dvalid_q;
  logic          grant_disp;
  logic          grant_fill;
  logic          grant_wr;

  // Grants are purely combinational so WACK lands in the same cycle as the write.
  assign grant_disp = !RST && bus.DREQ;
  assign grant_fill = !RST && !bus.DREQ && (state == ST_FILL);
  assign grant_wr   = !RST && !bus.DREQ && (state == ST_IDLE) && bus.WREQ;

  assign bus.MEN    = grant_disp | grant_fill | grant_wr;
  assign bus.MWE    = grant_fill | grant_wr;
  assign bus.WACK   = grant_wr;
  assign bus.MADDR  = grant_disp ? bus.DADDR : (grant_fill ? cnt : bus.WADDR);
  assign bus.MWDATA = grant_fill ? FILL : bus.WDATA;

  assign bus.DDATA  = bus.MRDATA;
  assign bus.DVALID = dvalid_q;
  assign bus.BUSY   = (state == ST_FILL);
  assign bus.DONE   = done_q;

  // The fill address only advances on cycles the fill actually owns the port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      done_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= bus.DREQ;
      done_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.CLR) begin
            state <= ST_FILL;
            cnt   <= '0;
          end
        end
        default: begin
          if (grant_fill) begin
            if (cnt == LAST) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
